exec_pipe: RTL and testbench

Parametrised execute stage for the in-order core, sitting between register-read and memory/writeback. It is the next generation of the two-register execute stage. Width-generic, two-stage pipeline (operand latch -> ALU -> result latch) with valid/ready flow control, synchronous flush, and operand bypass from its own in-flight results so back-to-back dependent instructions issue without bubbles. Store data and writeback metadata travel alongside the result.

---
 rtl/exec_pkg.sv | 23 ++
 rtl/alu_p.sv | 39 +++
 rtl/exec_pipe.sv | 130 +++++++++++++
 tb/tb_exec_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: ALU opcode codes and sizing helpers.
package exec_pkg;

    localparam int CTRL_W = 6;

    localparam int ALU_ADD   = 0;
    localparam int ALU_SUB   = 1;
    localparam int ALU_AND   = 2;
    localparam int ALU_OR    = 3;
    localparam int ALU_XOR   = 4;
    localparam int ALU_SLL   = 5;
    localparam int ALU_SRL   = 6;
    localparam int ALU_SRA   = 7;
    localparam int ALU_SLT   = 8;
    localparam int ALU_SLTU  = 9;
    localparam int ALU_PASSB = 10;

    // Number of low operand bits that form a shift amount for a given datapath width.
    function automatic int shamt_w(input int xlen);
        return $clog2(xlen);
    endfunction

endpackage

// File: rtl/alu_p.sv
// Combinational ALU for the execute stage; unknown opcodes produce zero.
module alu_p
    import exec_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int CTRL_W = exec_pkg::CTRL_W
) (
    input  logic [CTRL_W-1:0] ctrl,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [XLEN-1:0]   y
);

    localparam int SW = shamt_w(XLEN);

    logic [SW-1:0] shamt;

    assign shamt = b[SW-1:0];

    // Opcode decode; add/sub wrap naturally at XLEN bits.
    always_comb begin
        y = '0;
        case (int'(ctrl))
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_AND:   y = a & b;
            ALU_OR:    y = a | b;
            ALU_XOR:   y = a ^ b;
            ALU_SLL:   y = a << shamt;
            ALU_SRL:   y = a >> shamt;
            ALU_SRA:   y = $unsigned($signed(a) >>> shamt);
            ALU_SLT:   y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:  y = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_PASSB: y = b;
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/exec_pipe.sv
// Two-stage execute pipeline: operand latch (S1) -> ALU -> result latch (S2),
// valid/ready flow control, synchronous flush, and forwarding from both stages.
module exec_pipe
    import exec_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int RADDR_W = 5,
    parameter int IMM_W   = 12,
    parameter int CTRL_W  = exec_pkg::CTRL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTRL_W-1:0]  ctrl,
    input  logic [XLEN-1:0]    in1,
    input  logic [XLEN-1:0]    in2,
    input  logic [RADDR_W-1:0] src1_addr,
    input  logic [RADDR_W-1:0] src2_addr,
    input  logic               wb_en_in,
    input  logic [RADDR_W-1:0] wb_addr_in,
    input  logic [IMM_W-1:0]   wb_imm_in,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out,
    output logic               wb_en_out,
    output logic [RADDR_W-1:0] wb_addr_out,
    output logic [IMM_W-1:0]   wb_imm_out,
    output logic [XLEN-1:0]    mem_data
);

    logic               v1;
    logic [CTRL_W-1:0]  ctrl1;
    logic [XLEN-1:0]    a1;
    logic [XLEN-1:0]    b1;
    logic               wb_en1;
    logic [RADDR_W-1:0] wb_addr1;
    logic [IMM_W-1:0]   imm1;

    logic [XLEN-1:0]    y1;
    logic               adv1;
    logic               adv2;
    logic               accept;
    logic [XLEN-1:0]    op1;
    logic [XLEN-1:0]    op2;

    // No skid buffer: in_ready is combinational from out_ready through the stage-advance chain.
    assign adv2     = !out_valid || out_ready;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1;
    assign accept   = in_valid && adv1 && !flush;

    alu_p #(
        .XLEN   (XLEN),
        .CTRL_W (CTRL_W)
    ) u_alu (
        .ctrl (ctrl1),
        .a    (a1),
        .b    (b1),
        .y    (y1)
    );

    // Operand forwarding: the younger S1 result beats S2; register 0 is never forwarded.
    always_comb begin
        op1 = in1;
        op2 = in2;
        if (src1_addr != '0) begin
            if (v1 && wb_en1 && (wb_addr1 == src1_addr)) begin
                op1 = y1;
            end else if (out_valid && wb_en_out && (wb_addr_out == src1_addr)) begin
                op1 = out;
            end
        end
        if (src2_addr != '0) begin
            if (v1 && wb_en1 && (wb_addr1 == src2_addr)) begin
                op2 = y1;
            end else if (out_valid && wb_en_out && (wb_addr_out == src2_addr)) begin
                op2 = out;
            end
        end
    end

    // S1 operand latch: load on accept, drain when advancing, kill on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            ctrl1    <= '0;
            a1       <= '0;
            b1       <= '0;
            wb_en1   <= 1'b0;
            wb_addr1 <= '0;
            imm1     <= '0;
        end else if (flush) begin
            v1 <= 1'b0;
        end else if (accept) begin
            v1       <= 1'b1;
            ctrl1    <= ctrl;
            a1       <= op1;
            b1       <= op2;
            wb_en1   <= wb_en_in;
            wb_addr1 <= wb_addr_in;
            imm1     <= wb_imm_in;
        end else if (adv1) begin
            v1 <= 1'b0;
        end
    end

    // S2 result latch: holds while downstream stalls, flush clears valid regardless of out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out         <= '0;
            mem_data    <= '0;
            wb_en_out   <= 1'b0;
            wb_addr_out <= '0;
            wb_imm_out  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv2) begin
            out_valid   <= v1;
            out         <= y1;
            mem_data    <= b1;
            wb_en_out   <= wb_en1;
            wb_addr_out <= wb_addr1;
            wb_imm_out  <= imm1;
        end
    end

endmodule

// File: tb/tb_exec_pipe.sv
// Self-checking bench for exec_pipe: directed scenarios followed by random traffic,
// checked against an in-order architectural model (sequential register semantics).
module tb_exec_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  ctrl;
    logic [63:0] in1;
    logic [63:0] in2;
    logic [4:0]  src1_addr;
    logic [4:0]  src2_addr;
    logic        wb_en_in;
    logic [4:0]  wb_addr_in;
    logic [11:0] wb_imm_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out;
    logic        wb_en_out;
    logic [4:0]  wb_addr_out;
    logic [11:0] wb_imm_out;
    logic [63:0] mem_data;

    exec_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ctrl        (ctrl),
        .in1         (in1),
        .in2         (in2),
        .src1_addr   (src1_addr),
        .src2_addr   (src2_addr),
        .wb_en_in    (wb_en_in),
        .wb_addr_in  (wb_addr_in),
        .wb_imm_in   (wb_imm_in),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out),
        .wb_en_out   (wb_en_out),
        .wb_addr_out (wb_addr_out),
        .wb_imm_out  (wb_imm_out),
        .mem_data    (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] y;
        logic [63:0] b;
        logic        wb_en;
        logic [4:0]  addr;
        logic [11:0] imm;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [63:0] committed [32];
    logic [63:0] arch      [32];
    int          cyc;
    int          n_total;
    int          n_pass;
    int          n_fail;

    logic        s_iv;
    logic [5:0]  s_ctrl;
    logic [4:0]  s_src1;
    logic [4:0]  s_src2;
    logic [63:0] s_raw1;
    logic [63:0] s_raw2;
    logic        s_wben;
    logic [4:0]  s_wbaddr;
    logic [11:0] s_imm;
    logic        s_ordy;
    logic        s_flush;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [63:0] ref_alu(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        int                 sh;
        sa = a;
        sb = b;
        sh = int'(b % 64);
        case (op)
            6'd0:    return a + b;
            6'd1:    return a - b;
            6'd2:    return a & b;
            6'd3:    return a | b;
            6'd4:    return a ^ b;
            6'd5:    return a << sh;
            6'd6:    return a >> sh;
            6'd7:    return sa >>> sh;
            6'd8:    return (sa < sb) ? 64'd1 : 64'd0;
            6'd9:    return (a < b) ? 64'd1 : 64'd0;
            6'd10:   return b;
            default: return 64'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at the falling edge, check settled outputs, then advance the model.
    task automatic step();
        exp_t        e;
        logic [63:0] a;
        logic [63:0] b;
        logic        exp_ir;
        logic        exp_ov;
        logic        retire;
        logic        accept;
        @(negedge clk);
        cyc++;
        in_valid   = s_iv;
        ctrl       = s_ctrl;
        src1_addr  = s_src1;
        src2_addr  = s_src2;
        in1        = (s_src1 == 5'd0) ? s_raw1 : committed[s_src1];
        in2        = (s_src2 == 5'd0) ? s_raw2 : committed[s_src2];
        wb_en_in   = s_wben;
        wb_addr_in = s_wbaddr;
        wb_imm_in  = s_imm;
        out_ready  = s_ordy;
        flush      = s_flush;
        #1;
        exp_ir = (q.size() < 2) || s_ordy;
        exp_ov = (q.size() == 2) || (q.size() == 1 && (cyc - q[0].acc) >= 2);
        chk("in_ready", 64'(in_ready), 64'(exp_ir));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov) begin
            chk("out", out, q[0].y);
            chk("mem_data", mem_data, q[0].b);
            chk("wb_en_out", 64'(wb_en_out), 64'(q[0].wb_en));
            chk("wb_addr_out", 64'(wb_addr_out), 64'(q[0].addr));
            chk("wb_imm_out", 64'(wb_imm_out), 64'(q[0].imm));
        end
        retire = exp_ov && s_ordy && !s_flush;
        accept = s_iv && exp_ir && !s_flush;
        if (s_flush) begin
            q.delete();
            arch = committed;
        end else begin
            if (retire) begin
                e = q.pop_front();
                if (e.wb_en && e.addr != 5'd0) committed[e.addr] = e.y;
            end
            if (accept) begin
                a       = (s_src1 == 5'd0) ? s_raw1 : arch[s_src1];
                b       = (s_src2 == 5'd0) ? s_raw2 : arch[s_src2];
                e.y     = ref_alu(s_ctrl, a, b);
                e.b     = b;
                e.wb_en = s_wben;
                e.addr  = s_wbaddr;
                e.imm   = s_imm;
                e.acc   = cyc;
                q.push_back(e);
                if (s_wben && s_wbaddr != 5'd0) arch[s_wbaddr] = e.y;
            end
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic [4:0] sa, input logic [4:0] sb,
                         input logic [63:0] ra, input logic [63:0] rb,
                         input logic we, input logic [4:0] wa, input logic ordy);
        s_iv = 1'b1; s_ctrl = op; s_src1 = sa; s_src2 = sb; s_raw1 = ra; s_raw2 = rb;
        s_wben = we; s_wbaddr = wa; s_imm = 12'($urandom); s_ordy = ordy; s_flush = 1'b0;
        step();
    endtask

    task automatic idle(input logic ordy);
        s_iv = 1'b0; s_ordy = ordy; s_flush = 1'b0;
        s_raw1 = {$urandom, $urandom}; s_raw2 = {$urandom, $urandom};
        step();
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && q.size() > 0; i++) idle(1'b1);
    endtask

    initial begin
        logic [63:0] lits [5];
        n_total = 0; n_pass = 0; n_fail = 0; cyc = 0;
        for (int i = 0; i < 32; i++) begin committed[i] = 64'd0; arch[i] = 64'd0; end
        rst_n = 1'b0; in_valid = 1'b0; ctrl = '0; in1 = '0; in2 = '0; src1_addr = '0; src2_addr = '0;
        wb_en_in = 1'b0; wb_addr_in = '0; wb_imm_in = '0; flush = 1'b0; out_ready = 1'b1;
        s_iv = 0; s_ctrl = 0; s_src1 = 0; s_src2 = 0; s_raw1 = 0; s_raw2 = 0;
        s_wben = 0; s_wbaddr = 0; s_imm = 0; s_ordy = 1; s_flush = 0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out", out, 64'd0);
        chk("rst_mem_data", mem_data, 64'd0);
        chk("rst_wb_en_out", 64'(wb_en_out), 64'd0);
        chk("rst_wb_addr_out", 64'(wb_addr_out), 64'd0);
        chk("rst_wb_imm_out", 64'(wb_imm_out), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // ADD 5+7 -> x3, visible two edges after acceptance
        issue(6'd0, 5'd0, 5'd0, 64'd5, 64'd7, 1'b1, 5'd3, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("add_out", out, 64'd12);
        chk("add_wb_addr", 64'(wb_addr_out), 64'd3);
        drain();

        // back-to-back dependency, S1 forward
        issue(6'd0, 5'd0, 5'd0, 64'd10, 64'd20, 1'b1, 5'd1, 1'b1);
        issue(6'd0, 5'd1, 5'd0, 64'd0, 64'd1, 1'b1, 5'd2, 1'b1);
        idle(1'b1);
        chk("b2b_first", out, 64'd30);
        idle(1'b1);
        chk("b2b_s1_fwd", out, 64'd31);
        drain();

        // one-cycle gap, S2 forward (x4 is still 0 in the register file)
        issue(6'd0, 5'd0, 5'd0, 64'd10, 64'd20, 1'b1, 5'd4, 1'b1);
        idle(1'b1);
        issue(6'd0, 5'd4, 5'd0, 64'd0, 64'd1, 1'b1, 5'd5, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("gap_s2_fwd", out, 64'd31);
        drain();

        // producer writing x0 is never forwarded
        issue(6'd0, 5'd0, 5'd0, 64'd3, 64'd4, 1'b1, 5'd0, 1'b1);
        issue(6'd0, 5'd0, 5'd0, 64'd100, 64'd1, 1'b1, 5'd6, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("x0_no_fwd", out, 64'd101);
        drain();

        // producer with wb_en=0 is never forwarded
        issue(6'd0, 5'd0, 5'd0, 64'd50, 64'd0, 1'b0, 5'd7, 1'b1);
        issue(6'd0, 5'd7, 5'd0, 64'd0, 64'd1, 1'b1, 5'd8, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("noen_no_fwd", out, 64'd1);
        drain();

        // stall: three offered with out_ready low, two captured
        issue(6'd0, 5'd0, 5'd0, 64'd1, 64'd1, 1'b0, 5'd0, 1'b0);
        issue(6'd0, 5'd0, 5'd0, 64'd2, 64'd2, 1'b0, 5'd0, 1'b0);
        issue(6'd0, 5'd0, 5'd0, 64'd3, 64'd3, 1'b0, 5'd0, 1'b0);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_out_a", out, 64'd2);
        idle(1'b0);
        chk("stall_out_b", out, 64'd2);
        idle(1'b1);
        chk("release_first", out, 64'd2);
        idle(1'b1);
        chk("release_second", out, 64'd4);
        idle(1'b1);
        chk("release_none_left", 64'(out_valid), 64'd0);
        drain();

        // flush with both stages full and a new instruction offered
        issue(6'd0, 5'd0, 5'd0, 64'd1, 64'd1, 1'b1, 5'd9, 1'b0);
        issue(6'd0, 5'd0, 5'd0, 64'd2, 64'd2, 1'b1, 5'd10, 1'b0);
        s_iv = 1'b1; s_ctrl = 6'd0; s_src1 = 0; s_src2 = 0; s_raw1 = 64'd7; s_raw2 = 64'd7;
        s_wben = 1'b1; s_wbaddr = 5'd11; s_ordy = 1'b0; s_flush = 1'b1;
        step();
        idle(1'b1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        idle(1'b1);
        chk("flush_dropped", 64'(out_valid), 64'd0);

        // ALU corner cases issued back-to-back
        lits[0] = ONES; lits[1] = 64'd1; lits[2] = 64'd0; lits[3] = ONES; lits[4] = 64'd0;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: issue(6'd7,  5'd0, 5'd0, 64'h8000_0000_0000_0000, 64'd63, 1'b0, 5'd0, 1'b1);
                1: issue(6'd8,  5'd0, 5'd0, ONES, 64'd1, 1'b0, 5'd0, 1'b1);
                2: issue(6'd9,  5'd0, 5'd0, ONES, 64'd1, 1'b0, 5'd0, 1'b1);
                3: issue(6'd1,  5'd0, 5'd0, 64'd0, 64'd1, 1'b0, 5'd0, 1'b1);
                4: issue(6'd63, 5'd0, 5'd0, 64'd123, 64'd456, 1'b0, 5'd0, 1'b1);
                default: idle(1'b1);
            endcase
            if (i >= 2) chk($sformatf("alu_corner_%0d", i - 2), out, lits[i - 2]);
        end
        drain();

        // random traffic against the architectural model
        for (int n = 0; n < 600; n++) begin
            s_iv     = ($urandom_range(0, 9) < 7);
            s_ctrl   = ($urandom_range(0, 19) == 0) ? 6'($urandom_range(11, 63)) : 6'($urandom_range(0, 10));
            s_src1   = 5'($urandom_range(0, 7));
            s_src2   = 5'($urandom_range(0, 7));
            s_raw1   = {$urandom, $urandom};
            s_raw2   = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom};
            s_wben   = ($urandom_range(0, 3) != 0);
            s_wbaddr = 5'($urandom_range(0, 7));
            s_imm    = 12'($urandom);
            s_ordy   = ($urandom_range(0, 9) < 7);
            s_flush  = ($urandom_range(0, 39) == 0);
            step();
        end
        drain();
        idle(1'b1);
        chk("end_out_valid", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
